// File: rtl/cpe_mem_arb.sv
// cpe_mem_arb: shares one memory port between the IF and LS requesters, with a wait-state timeout.
// Define CPE_MEM_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed LS priority.
module cpe_mem_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_w_i,
    input  logic              res_w_i_l,
    input  logic              if_req_w_i_h,
    input  logic [ADDR_W-1:0] if_addr_w_i,
    output logic              if_gnt_w_o_h,
    output logic              if_rvalid_w_o_h,
    output logic [DATA_W-1:0] if_rdata_w_o,
    input  logic              ls_req_w_i_h,
    input  logic              ls_we_w_i_h,
    input  logic [ADDR_W-1:0] ls_addr_w_i,
    input  logic [DATA_W-1:0] ls_wdata_w_i,
    output logic              ls_gnt_w_o_h,
    output logic              ls_rvalid_w_o_h,
    output logic [DATA_W-1:0] ls_rdata_w_o,
    output logic [ADDR_W-1:0] mem_addr_w_o,
    output logic [DATA_W-1:0] mem_wdata_w_o,
    output logic              mem_rd_w_o_h,
    output logic              mem_wr_w_o_h,
    input  logic [DATA_W-1:0] mem_rdata_w_i,
    input  logic              mem_rdy_w_i_h,
    output logic              err_w_o_h
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic             OWN_IF   = 1'b0;
    localparam logic             OWN_LS   = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    logic              owner_q,     owner_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q,  ls_rdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic              err_q,       err_d;

    logic idle;
    logic ls_prio;
    logic ls_win;
    logic if_win;

    assign idle = (state_q == ST_IDLE);

`ifdef CPE_MEM_ARB_RR_EN
    // Remembers who was granted last; reset value IF hands the first tie to LS.
    logic last_ls_q, last_ls_d;

    assign ls_prio = !last_ls_q;

    always_comb begin
        last_ls_d = last_ls_q;
        if (ls_win) begin
            last_ls_d = 1'b1;
        end else if (if_win) begin
            last_ls_d = 1'b0;
        end
    end

    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            last_ls_q <= 1'b0;
        end else begin
            last_ls_q <= last_ls_d;
        end
    end
`else
    assign ls_prio = 1'b1;
`endif

    // Grants are combinational from the requests and only exist in IDLE.
    assign ls_win = idle && ls_req_w_i_h && (!if_req_w_i_h || ls_prio);
    assign if_win = idle && if_req_w_i_h && !(ls_req_w_i_h && ls_prio);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ls_win) begin
                    state_d = ST_ACCESS;
                    owner_d = OWN_LS;
                    we_d    = ls_we_w_i_h;
                    addr_d  = ls_addr_w_i;
                    wdata_d = ls_wdata_w_i;
                    cnt_d   = '0;
                end else if (if_win) begin
                    // IF carries no write data, so the write-data register keeps its value.
                    state_d = ST_ACCESS;
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = if_addr_w_i;
                    cnt_d   = '0;
                end
            end
            ST_ACCESS: begin
                if (mem_rdy_w_i_h) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_LS) begin
                        ls_rvalid_d = 1'b1;
                        if (!we_q) begin
                            ls_rdata_d = mem_rdata_w_i;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata_w_i;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: the owner still sees a completion, with zero data and err.
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    if (owner_q == OWN_LS) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = '0;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            err_q       <= err_d;
        end
    end

    assign if_gnt_w_o_h    = if_win;
    assign ls_gnt_w_o_h    = ls_win;
    assign if_rvalid_w_o_h = if_rvalid_q;
    assign ls_rvalid_w_o_h = ls_rvalid_q;
    assign if_rdata_w_o    = if_rdata_q;
    assign ls_rdata_w_o    = ls_rdata_q;
    assign err_w_o_h       = err_q;
    assign mem_addr_w_o    = addr_q;
    assign mem_wdata_w_o   = wdata_q;
    // Strobes decode straight from state so an async reset drops them immediately.
    assign mem_rd_w_o_h    = !idle && !we_q;
    assign mem_wr_w_o_h    = !idle && we_q;

    a_one_grant: assert property (@(posedge clk_w_i) disable iff (!res_w_i_l)
        !(if_gnt_w_o_h && ls_gnt_w_o_h));
    a_gnt_idle: assert property (@(posedge clk_w_i) disable iff (!res_w_i_l)
        (if_gnt_w_o_h || ls_gnt_w_o_h) |-> idle);

endmodule
